// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the serial pattern detector.
package seq_det_pkg;

    localparam int MAX_LEN_DFLT   = 8;
    localparam int CNT_W_DFLT     = 16;
    localparam int TIMEOUT_W_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TIMEOUT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/prog_pattern_matcher.sv
// Shift history, fill counter and length-masked compare.
module prog_pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DFLT,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_next;

    always_comb begin
        w_hist_next = {r_hist[MAX_LEN-2:0], in};
        w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill
                                                  : r_fill + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < len);
        end
    end

    assign match = shift_en
                && (w_fill_next >= len)
                && (((w_hist_next ^ pattern) & w_mask) == '0);

    // Without overlap the history stays but must be refilled before the next hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift_en) begin
            r_hist <= w_hist_next;
            r_fill <= (match && !overlap) ? '0 : w_fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Config, arming FSM, timeout supervision and hit counting
// around a programmable serial pattern matcher.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN   = MAX_LEN_DFLT,
    parameter int CNT_W     = CNT_W_DFLT,
    parameter int TIMEOUT_W = TIMEOUT_W_DFLT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [TIMEOUT_W-1:0]         cfg_timeout,
    input  logic                         arm,
    input  logic                         disarm,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         detected,
    output logic [CNT_W-1:0]             hit_count,
    output logic                         timeout_flag,
    output logic                         busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [TIMEOUT_W-1:0] w_timer_inc;
    logic [CNT_W-1:0]     r_hit;
    logic                 r_detected;
    logic                 w_arm_go;
    logic                 w_clr;
    logic                 w_shift_en;
    logic                 w_match;

    // Arm/disarm in the same cycle pre-empt any sampling of the serial bit.
    assign w_shift_en  = (r_state == ARMED) && in_valid && !arm && !disarm;
    assign w_timer_inc = (&r_timer) ? r_timer : r_timer + TIMEOUT_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_arm_go     = 1'b0;
        w_clr        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (arm && !disarm && r_len != '0) begin
                    w_state_next = ARMED;
                    w_arm_go     = 1'b1;
                    w_clr        = 1'b1;
                end
            end
            ARMED: begin
                if (disarm) begin
                    w_state_next = IDLE;
                    w_clr        = 1'b1;
                end else if (arm) begin
                    w_arm_go = 1'b1;
                    w_clr    = 1'b1;
                end else if (r_timeout != '0 && !w_match
                             && w_timer_inc >= r_timeout) begin
                    w_state_next = TIMEOUT;
                end
            end
            TIMEOUT: begin
                if (disarm) begin
                    w_state_next = IDLE;
                    w_clr        = 1'b1;
                end else if (arm) begin
                    w_state_next = ARMED;
                    w_arm_go     = 1'b1;
                    w_clr        = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_timeout <= '0;
        end else if (cfg_valid && cfg_ready) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_timeout <= cfg_timeout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer    <= '0;
            r_hit      <= '0;
            r_detected <= 1'b0;
        end else begin
            r_detected <= w_match;
            if (w_clr) begin
                r_timer <= '0;
            end else if (r_state == ARMED) begin
                r_timer <= w_match ? '0 : w_timer_inc;
            end
            if (w_arm_go) begin
                r_hit <= '0;
            end else if (w_match && !(&r_hit)) begin
                r_hit <= r_hit + CNT_W'(1);
            end
        end
    end

    prog_pattern_matcher #(
        .MAX_LEN (MAX_LEN)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift_en),
        .in       (in),
        .pattern  (r_pattern),
        .len      (r_len),
        .overlap  (r_overlap),
        .match    (w_match)
    );

    assign cfg_ready    = (r_state == IDLE);
    assign busy         = (r_state == ARMED);
    assign timeout_flag = (r_state == TIMEOUT);
    assign detected     = r_detected;
    assign hit_count    = r_hit;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench: stimulus queues expected detects, a monitor pops them.
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_pattern = '0;
    logic [3:0]  cfg_len = '0;
    logic        cfg_overlap = 1'b0;
    logic [15:0] cfg_timeout = '0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;

    logic        cfg_ready, detected, timeout_flag, busy;
    logic [15:0] hit_count;
    logic        cfg_ready2, detected2, timeout_flag2, busy2;
    logic [1:0]  hit_count2;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    seq_detect_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_timeout(cfg_timeout),
        .arm(arm), .disarm(disarm),
        .in_valid(in_valid), .in(in_bit),
        .detected(detected), .hit_count(hit_count),
        .timeout_flag(timeout_flag), .busy(busy)
    );

    seq_detect_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_timeout(cfg_timeout),
        .arm(arm), .disarm(disarm),
        .in_valid(in_valid), .in(in_bit),
        .detected(detected2), .hit_count(hit_count2),
        .timeout_flag(timeout_flag2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                       input logic ov, input logic [15:0] to);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_timeout = to;
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic do_disarm();
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
    endtask

    task automatic sbit(input logic b, input logic exp_det,
                        input logic [15:0] exp_hit);
        in_valid = 1'b1;
        in_bit   = b;
        if (exp_det) exp_q.push_back(exp_hit);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d detects outstanding, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && detected) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_detect: got detect hit_count=%0d, expected none",
                             hit_count);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (hit_count !== mon_exp) begin
                        errors++;
                        $display("FAIL detect_hit_count: got %0d expected %0d",
                                 hit_count, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_detected", detected, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_tflag", timeout_flag, 0);
        rst = 1'b1;
        cyc();

        // 1) overlapping AA detect
        cfg(8'hAA, 4'd8, 1'b1, 16'd0);
        do_arm();
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            sbit((i % 2) == 0, (i == 7) || (i == 9), (i == 7) ? 16'd1 : 16'd2);
        end
        drain("t1_drain");
        chk("t1_hit", hit_count, 2);
        do_disarm();
        chk("t1_disarm_busy", busy, 0);
        chk("t1_hit_retained", hit_count, 2);

        // 2) non-overlapping
        cfg(8'hAA, 4'd8, 1'b0, 16'd0);
        do_arm();
        chk("t2_hit_cleared", hit_count, 0);
        for (int i = 0; i < 10; i++) begin
            sbit((i % 2) == 0, i == 7, 16'd1);
        end
        drain("t2_drain");
        chk("t2_hit", hit_count, 1);
        do_disarm();

        // 3) timeout
        cfg(8'h05, 4'd3, 1'b1, 16'd5);
        do_arm();
        repeat (4) cyc();
        chk("t3_busy_before", busy, 1);
        chk("t3_tflag_before", timeout_flag, 0);
        cyc();
        chk("t3_tflag", timeout_flag, 1);
        chk("t3_busy_after", busy, 0);
        chk("t3_ready_in_timeout", cfg_ready, 0);
        do_disarm();
        chk("t3_tflag_clear", timeout_flag, 0);
        chk("t3_ready_idle", cfg_ready, 1);

        // 4) config refused while armed, arm+disarm
        cfg(8'h05, 4'd3, 1'b1, 16'd0);
        do_arm();
        cfg_valid   = 1'b1;
        cfg_pattern = 8'h02;
        #1;
        chk("t4_ready_armed", cfg_ready, 0);
        cyc();
        cfg_valid = 1'b0;
        sbit(1'b1, 1'b0, 16'd0);
        sbit(1'b0, 1'b0, 16'd0);
        sbit(1'b1, 1'b1, 16'd1);
        drain("t4_drain");
        arm    = 1'b1;
        disarm = 1'b1;
        cyc();
        arm    = 1'b0;
        disarm = 1'b0;
        chk("t4_both_busy", busy, 0);
        chk("t4_both_ready", cfg_ready, 1);
        chk("t4_hit", hit_count, 1);

        // 5) saturation with a 2-bit counter
        cfg(8'h01, 4'd1, 1'b1, 16'd0);
        do_arm();
        for (int k = 0; k < 5; k++) begin
            sbit(1'b1, 1'b1, 16'(k + 1));
        end
        drain("t5_drain");
        chk("t5_hit", hit_count, 5);
        chk("t5_sat", hit_count2, 3);
        do_disarm();

        // 6) reset mid-pattern
        cfg(8'hAA, 4'd8, 1'b1, 16'd0);
        do_arm();
        sbit(1'b1, 1'b0, 16'd0);
        sbit(1'b0, 1'b0, 16'd0);
        sbit(1'b1, 1'b0, 16'd0);
        sbit(1'b0, 1'b0, 16'd0);
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", cfg_ready, 1);
        chk("t6_rst_detected", detected, 0);
        chk("t6_rst_tflag", timeout_flag, 0);
        cyc();
        rst = 1'b1;
        cyc();
        do_arm();
        chk("t6_arm_len0", busy, 0);
        cfg(8'hAA, 4'd8, 1'b1, 16'd0);
        do_arm();
        chk("t6_armed", busy, 1);
        sbit(1'b1, 1'b0, 16'd0);
        sbit(1'b0, 1'b0, 16'd0);
        sbit(1'b1, 1'b0, 16'd0);
        sbit(1'b0, 1'b0, 16'd0);
        drain("t6_drain");
        chk("t6_hit", hit_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
